regfile_alu_pipe: RTL and testbench

//  Parametrised successor of the single-cycle register-file/ALU datapath.
//  Two-stage pipeline: EX (read operands, immediate select, ALU) -> WB
//  (registered result, register-file write). Adds forwarding, stall, a

---
 rtl/regfile_alu_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_regfile_alu_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_pipe.sv
// regfile_alu_pipe
//   Two-stage register-file/ALU datapath that sits between the instruction
//   decoder and the memory/IO stage. The EX stage reads operands, selects the
//   immediate and runs the ALU. The WB stage holds the registered result and
//   writes it back into the register file. Dependent instructions issued
//   back-to-back never stall, because the WB value is forwarded into EX.
//
//   Parameters
//     WIDTH    datapath and register width (>= 8)
//     NREGS    number of registers, power of two
//     ZERO_R0  1: R0 always reads as zero and writes to it are dropped
//
//   Ports
//     Clk, Rst          clock, synchronous active-high reset
//     Valid, Stall      instruction present / freeze the whole pipeline
//     RdestRegLoc       destination and first operand (A)
//     RsrcRegLoc        second operand (B) when Imm_s = 0
//     Imm_s, Imm        immediate select, pre-extended immediate
//     OpCode            ALU operation
//     DbgRegLoc/DbgOut  combinational register-file peek, no forwarding
//     WbValid, WbRegLoc, WbData   WB stage contents
//     Flags             {C,L,F,Z,N}, registered
module regfile_alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 16,
    parameter bit ZERO_R0 = 1'b0,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Valid,
    input  logic             Stall,
    input  logic [AW-1:0]    RdestRegLoc,
    input  logic [AW-1:0]    RsrcRegLoc,
    input  logic             Imm_s,
    input  logic [WIDTH-1:0] Imm,
    input  logic [3:0]       OpCode,
    input  logic [AW-1:0]    DbgRegLoc,
    output logic [WIDTH-1:0] DbgOut,
    output logic             WbValid,
    output logic [AW-1:0]    WbRegLoc,
    output logic [WIDTH-1:0] WbData,
    output logic [4:0]       Flags
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_CMP = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_MOV = 4'd6,
        OP_LSH = 4'd7
    } aluOp_e;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;
    localparam int MSB    = WIDTH - 1;

    logic [WIDTH-1:0] regFile [NREGS];
    logic             wbWe;
    logic             wbCommit;
    aluOp_e           aluOp;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] rsrcVal;
    logic [WIDTH-1:0] opB;
    logic [WIDTH:0]   sumExt;
    logic [WIDTH:0]   diffExt;
    logic [4:0]       shiftField;
    logic [4:0]       shiftMag;
    logic [WIDTH-1:0] shiftOut;
    logic [WIDTH-1:0] aluResult;
    logic             aluWrites;
    logic [4:0]       nextFlags;

    function automatic logic isZeroReg(input logic [AW-1:0] idx);
        return ZERO_R0 && (idx == '0);
    endfunction

    // The WB write is real only if it targets a writable register. The same
    // condition qualifies forwarding, so a dropped R0 write is never forwarded.
    assign wbCommit = WbValid && wbWe && !isZeroReg(WbRegLoc);
    assign aluOp    = aluOp_e'(OpCode);

    // Operand fetch: the WB value overrides the register file when it is about
    // to be written to the same register, which is what makes back-to-back
    // dependent instructions see the newest value.
    always_comb begin
        if (isZeroReg(RdestRegLoc)) begin
            opA = '0;
        end else if (wbCommit && (WbRegLoc == RdestRegLoc)) begin
            opA = WbData;
        end else begin
            opA = regFile[RdestRegLoc];
        end

        if (isZeroReg(RsrcRegLoc)) begin
            rsrcVal = '0;
        end else if (wbCommit && (WbRegLoc == RsrcRegLoc)) begin
            rsrcVal = WbData;
        end else begin
            rsrcVal = regFile[RsrcRegLoc];
        end

        opB = Imm_s ? Imm : rsrcVal;
    end

    // Shifter: B[4:0] is a signed distance, negative shifts right. The
    // magnitude of -16 still fits in five unsigned bits.
    always_comb begin
        shiftField = opB[4:0];
        shiftMag   = shiftField[4] ? (5'd0 - shiftField) : shiftField;
        if ({27'd0, shiftMag} >= 32'(WIDTH)) begin
            shiftOut = '0;
        end else if (shiftField[4]) begin
            shiftOut = opA >> shiftMag;
        end else begin
            shiftOut = opA << shiftMag;
        end
    end

    // ALU: result, write decision and next flags. Flags not touched by an
    // operation keep their current value.
    always_comb begin
        sumExt    = {1'b0, opA} + {1'b0, opB};
        diffExt   = {1'b0, opA} - {1'b0, opB};
        aluResult = '0;
        aluWrites = 1'b0;
        nextFlags = Flags;
        case (aluOp)
            OP_ADD: begin
                aluResult         = sumExt[MSB:0];
                aluWrites         = 1'b1;
                nextFlags[FLAG_C] = sumExt[WIDTH];
                nextFlags[FLAG_F] = (opA[MSB] == opB[MSB]) && (sumExt[MSB] != opA[MSB]);
            end
            OP_SUB: begin
                aluResult         = diffExt[MSB:0];
                aluWrites         = 1'b1;
                nextFlags[FLAG_C] = diffExt[WIDTH];
                nextFlags[FLAG_F] = (opA[MSB] != opB[MSB]) && (diffExt[MSB] != opA[MSB]);
            end
            OP_CMP: begin
                nextFlags[FLAG_L] = diffExt[WIDTH];
                nextFlags[FLAG_Z] = (opA == opB);
                nextFlags[FLAG_N] = $signed(opA) < $signed(opB);
            end
            OP_AND: begin
                aluResult = opA & opB;
                aluWrites = 1'b1;
            end
            OP_OR: begin
                aluResult = opA | opB;
                aluWrites = 1'b1;
            end
            OP_XOR: begin
                aluResult = opA ^ opB;
                aluWrites = 1'b1;
            end
            OP_MOV: begin
                aluResult = opB;
                aluWrites = 1'b1;
            end
            OP_LSH: begin
                aluResult = shiftOut;
                aluWrites = 1'b1;
            end
            default: begin
                aluResult = '0;
                aluWrites = 1'b0;
            end
        endcase
    end

    // WB stage and flags. A stall freezes everything; an idle cycle empties
    // WB so the write it held cannot commit a second time.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            WbValid  <= 1'b0;
            WbRegLoc <= '0;
            WbData   <= '0;
            wbWe     <= 1'b0;
            Flags    <= '0;
        end else if (!Stall) begin
            WbValid <= Valid;
            wbWe    <= Valid && aluWrites;
            if (Valid) begin
                WbRegLoc <= RdestRegLoc;
                WbData   <= aluResult;
                Flags    <= nextFlags;
            end
        end
    end

    // Register file write port, fed only from WB. Reset discards any pending
    // WB write along with the register contents.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= '0;
            end
        end else if (!Stall && wbCommit) begin
            regFile[WbRegLoc] <= WbData;
        end
    end

    assign DbgOut = isZeroReg(DbgRegLoc) ? '0 : regFile[DbgRegLoc];

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// tb_regfile_alu_pipe
//   Bench for regfile_alu_pipe. Two instances share all inputs: one with a
//   normal R0 and one with ZERO_R0 = 1. Expected values come from a directed
//   vector table, hand-written corner sequences and an architectural model
//   of the datapath.
module tb_regfile_alu_pipe;

    localparam bit [3:0] opAdd = 4'd0;
    localparam bit [3:0] opSub = 4'd1;
    localparam bit [3:0] opCmp = 4'd2;
    localparam bit [3:0] opAnd = 4'd3;
    localparam bit [3:0] opOr  = 4'd4;
    localparam bit [3:0] opXor = 4'd5;
    localparam bit [3:0] opMov = 4'd6;
    localparam bit [3:0] opLsh = 4'd7;
    localparam bit [3:0] opNop = 4'd9;

    typedef struct {
        bit       valid;
        bit       stall;
        bit       rst;
        bit       immS;
        bit [3:0] rd;
        bit [3:0] rs;
        bit [3:0] op;
        bit [3:0] dbg;
        bit [15:0] imm;
    } stimT;

    typedef struct {
        stimT      s;
        bit        expWbValid;
        bit        chkData;
        bit [15:0] expData;
        bit [4:0]  expFlags;
        bit [15:0] expDbg;
    } vecT;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        stall;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic        immS;
    logic [15:0] imm;
    logic [3:0]  opCode;
    logic [3:0]  dbgRegLoc;

    logic [15:0] dbgOut,   dbgOutZ;
    logic        wbValid,  wbValidZ;
    logic [3:0]  wbRegLoc, wbRegLocZ;
    logic [15:0] wbData,   wbDataZ;
    logic [4:0]  flags,    flagsZ;

    int checks   = 0;
    int failures = 0;

    // Architectural model state, index 0 = normal R0, 1 = ZERO_R0 build
    int unsigned mRf [2][16];
    bit          mPendV [2];
    int unsigned mPendIdx [2];
    int unsigned mPendData [2];
    bit          mWbV [2];
    int unsigned mWbLoc [2];
    int unsigned mWbData [2];
    int unsigned mFlags [2];

    vecT vecs[$];

    regfile_alu_pipe #(.WIDTH(16), .NREGS(16), .ZERO_R0(1'b0)) dut (
        .Clk(clk), .Rst(rst), .Valid(valid), .Stall(stall),
        .RdestRegLoc(rdest), .RsrcRegLoc(rsrc), .Imm_s(immS), .Imm(imm),
        .OpCode(opCode), .DbgRegLoc(dbgRegLoc), .DbgOut(dbgOut),
        .WbValid(wbValid), .WbRegLoc(wbRegLoc), .WbData(wbData), .Flags(flags)
    );

    regfile_alu_pipe #(.WIDTH(16), .NREGS(16), .ZERO_R0(1'b1)) dutZ (
        .Clk(clk), .Rst(rst), .Valid(valid), .Stall(stall),
        .RdestRegLoc(rdest), .RsrcRegLoc(rsrc), .Imm_s(immS), .Imm(imm),
        .OpCode(opCode), .DbgRegLoc(dbgRegLoc), .DbgOut(dbgOutZ),
        .WbValid(wbValidZ), .WbRegLoc(wbRegLocZ), .WbData(wbDataZ), .Flags(flagsZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stimT ins(input bit [3:0] op, input bit [3:0] rd, input bit [3:0] rs,
                                 input bit iS, input bit [15:0] iv, input bit [3:0] dbg);
        stimT s;
        s.valid = 1'b1; s.stall = 1'b0; s.rst = 1'b0;
        s.op = op; s.rd = rd; s.rs = rs; s.immS = iS; s.imm = iv; s.dbg = dbg;
        return s;
    endfunction

    function automatic stimT idle(input bit [3:0] dbg);
        stimT s;
        s = ins(opNop, 4'd0, 4'd0, 1'b0, 16'h0000, dbg);
        s.valid = 1'b0;
        return s;
    endfunction

    function automatic int unsigned modelRead(input int z, input int unsigned idx);
        if (z == 1 && idx == 0) return 0;
        return mRf[z][idx];
    endfunction

    // Plain-arithmetic ALU on 16-bit values held in ints
    function automatic void aluModel(input int unsigned a, input int unsigned b, input int op,
                                     input int unsigned fIn, output int unsigned res,
                                     output bit wr, output int unsigned fOut);
        int sa, sb, sh;
        longint sr;
        sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
        res = 0; wr = 1'b0; fOut = fIn;
        case (op)
            0: begin
                res = (a + b) & 32'hFFFF; wr = 1'b1;
                sr = longint'(sa) + longint'(sb);
                fOut[4] = (a + b) > 65535;
                fOut[2] = (sr > 32767) || (sr < -32768);
            end
            1: begin
                res = (a - b) & 32'hFFFF; wr = 1'b1;
                sr = longint'(sa) - longint'(sb);
                fOut[4] = a < b;
                fOut[2] = (sr > 32767) || (sr < -32768);
            end
            2: begin
                fOut[3] = a < b;
                fOut[1] = a == b;
                fOut[0] = sa < sb;
            end
            3: begin res = a & b; wr = 1'b1; end
            4: begin res = a | b; wr = 1'b1; end
            5: begin res = a ^ b; wr = 1'b1; end
            6: begin res = b; wr = 1'b1; end
            7: begin
                sh = int'(b & 31);
                if (sh >= 16) sh = sh - 32;
                if (sh >= 0) res = (sh >= 16) ? 0 : ((a << sh) & 32'hFFFF);
                else res = (-sh >= 16) ? 0 : (a >> (-sh));
                wr = 1'b1;
            end
            default: ;
        endcase
    endfunction

    // Advance the model across one clock edge. Operands are read after the
    // pending write has been applied, giving sequential program semantics.
    task automatic modelEdge(input stimT s);
        int unsigned a, b, res, fOut;
        bit wr;
        for (int z = 0; z < 2; z++) begin
            if (s.rst) begin
                for (int r = 0; r < 16; r++) mRf[z][r] = 0;
                mPendV[z] = 1'b0; mWbV[z] = 1'b0; mWbLoc[z] = 0; mWbData[z] = 0; mFlags[z] = 0;
            end else if (!s.stall) begin
                if (mPendV[z] && !(z == 1 && mPendIdx[z] == 0)) mRf[z][mPendIdx[z]] = mPendData[z];
                a = modelRead(z, s.rd);
                b = s.immS ? int'(s.imm) : modelRead(z, s.rs);
                mWbV[z]   = s.valid;
                mPendV[z] = 1'b0;
                if (s.valid) begin
                    aluModel(a, b, int'(s.op), mFlags[z], res, wr, fOut);
                    mWbData[z] = res; mWbLoc[z] = s.rd; mFlags[z] = fOut;
                    mPendV[z] = wr; mPendIdx[z] = s.rd; mPendData[z] = res;
                end
            end
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkInst(input int z, input string tag, input logic v, input logic [3:0] loc,
                             input logic [15:0] data, input logic [4:0] fl, input logic [15:0] dbg);
        string p;
        p = $sformatf("%s/%s", tag, (z == 1) ? "zeroR0" : "normal");
        checkValue({p, ".wbValid"}, 32'(v), 32'(mWbV[z]));
        if (mWbV[z]) checkValue({p, ".wbRegLoc"}, 32'(loc), mWbLoc[z]);
        if (mWbV[z] && mPendV[z]) checkValue({p, ".wbData"}, 32'(data), mWbData[z]);
        checkValue({p, ".flags"}, 32'(fl), mFlags[z]);
        checkValue({p, ".dbgOut"}, 32'(dbg), modelRead(z, dbgRegLoc));
    endtask

    task automatic checkOutput(input string tag);
        checkInst(0, tag, wbValid, wbRegLoc, wbData, flags, dbgOut);
        checkInst(1, tag, wbValidZ, wbRegLocZ, wbDataZ, flagsZ, dbgOutZ);
    endtask

    task automatic applyStimulus(input stimT s);
        valid = s.valid; stall = s.stall; rst = s.rst;
        rdest = s.rd; rsrc = s.rs; immS = s.immS; imm = s.imm;
        opCode = s.op; dbgRegLoc = s.dbg;
        modelEdge(s);
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input stimT s, input bit v, input bit chk, input bit [15:0] d,
                          input bit [4:0] f, input bit [15:0] dbg);
        vecT r;
        r.s = s; r.expWbValid = v; r.chkData = chk; r.expData = d; r.expFlags = f; r.expDbg = dbg;
        vecs.push_back(r);
    endtask

    initial begin
        stimT s;

        for (int z = 0; z < 2; z++) begin
            for (int r = 0; r < 16; r++) mRf[z][r] = 0;
            mPendV[z] = 1'b0; mPendIdx[z] = 0; mPendData[z] = 0;
            mWbV[z] = 1'b0; mWbLoc[z] = 0; mWbData[z] = 0; mFlags[z] = 0;
        end
        valid = 1'b0; stall = 1'b0; rst = 1'b0; rdest = '0; rsrc = '0;
        immS = 1'b0; imm = '0; opCode = '0; dbgRegLoc = '0;

        // Directed vectors: {stimulus, wbValid, check data?, wbData, flags, dbgOut}
        s = ins(opMov, 4'd1, 4'd0, 1'b1, 16'h0005, 4'd1); s.rst = 1'b1;
        addVec(s,                                         0, 0, 16'h0000, 5'h00, 16'h0000);
        addVec(ins(opMov, 4'd1, 4'd0, 1, 16'h1234, 4'd1), 1, 1, 16'h1234, 5'h00, 16'h0000);
        addVec(ins(opAdd, 4'd1, 4'd0, 1, 16'h0001, 4'd1), 1, 1, 16'h1235, 5'h00, 16'h1234);
        addVec(idle(4'd1),                                0, 0, 16'h0000, 5'h00, 16'h1235);
        addVec(ins(opMov, 4'd2, 4'd0, 1, 16'hFFFF, 4'd2), 1, 1, 16'hFFFF, 5'h00, 16'h0000);
        addVec(ins(opAdd, 4'd2, 4'd0, 1, 16'h0001, 4'd2), 1, 1, 16'h0000, 5'h10, 16'hFFFF);
        addVec(ins(opMov, 4'd3, 4'd0, 1, 16'h7FFF, 4'd2), 1, 1, 16'h7FFF, 5'h10, 16'h0000);
        addVec(ins(opAdd, 4'd3, 4'd0, 1, 16'h0001, 4'd3), 1, 1, 16'h8000, 5'h04, 16'h7FFF);
        addVec(ins(opMov, 4'd4, 4'd0, 1, 16'h0005, 4'd3), 1, 1, 16'h0005, 5'h04, 16'h8000);
        addVec(ins(opMov, 4'd5, 4'd0, 1, 16'h0009, 4'd4), 1, 1, 16'h0009, 5'h04, 16'h0005);
        addVec(ins(opCmp, 4'd4, 4'd5, 0, 16'h0000, 4'd5), 1, 0, 16'h0000, 5'h0D, 16'h0009);
        addVec(ins(opCmp, 4'd5, 4'd5, 0, 16'h0000, 4'd4), 1, 0, 16'h0000, 5'h06, 16'h0005);
        addVec(idle(4'd4),                                0, 0, 16'h0000, 5'h06, 16'h0005);
        addVec(ins(opMov, 4'd6, 4'd0, 1, 16'h00F0, 4'd6), 1, 1, 16'h00F0, 5'h06, 16'h0000);
        addVec(ins(opLsh, 4'd6, 4'd0, 1, 16'hFFFC, 4'd6), 1, 1, 16'h000F, 5'h06, 16'h00F0);
        addVec(ins(opLsh, 4'd6, 4'd0, 1, 16'h0014, 4'd6), 1, 1, 16'h0000, 5'h06, 16'h000F);
        addVec(ins(opMov, 4'd6, 4'd0, 1, 16'h0003, 4'd6), 1, 1, 16'h0003, 5'h06, 16'h0000);
        addVec(ins(opLsh, 4'd6, 4'd0, 1, 16'h000F, 4'd6), 1, 1, 16'h8000, 5'h06, 16'h0003);
        addVec(ins(opLsh, 4'd6, 4'd0, 1, 16'hFFF0, 4'd6), 1, 1, 16'h0000, 5'h06, 16'h8000);
        addVec(ins(opMov, 4'd8, 4'd0, 1, 16'h0003, 4'd6), 1, 1, 16'h0003, 5'h06, 16'h0000);
        addVec(ins(opSub, 4'd8, 4'd0, 1, 16'h0005, 4'd8), 1, 1, 16'hFFFE, 5'h12, 16'h0003);
        addVec(ins(opXor, 4'd8, 4'd0, 1, 16'h00FF, 4'd8), 1, 1, 16'hFF01, 5'h12, 16'hFFFE);
        addVec(ins(opAnd, 4'd8, 4'd0, 1, 16'h0F0F, 4'd8), 1, 1, 16'h0F01, 5'h12, 16'hFF01);
        addVec(ins(opOr,  4'd8, 4'd0, 1, 16'hF000, 4'd8), 1, 1, 16'hFF01, 5'h12, 16'h0F01);
        addVec(ins(opNop, 4'd8, 4'd0, 1, 16'h0000, 4'd8), 1, 0, 16'h0000, 5'h12, 16'hFF01);
        addVec(ins(opMov, 4'd9, 4'd0, 1, 16'h8000, 4'd8), 1, 1, 16'h8000, 5'h12, 16'hFF01);
        addVec(ins(opSub, 4'd9, 4'd0, 1, 16'h0001, 4'd9), 1, 1, 16'h7FFF, 5'h06, 16'h8000);
        addVec(ins(opMov, 4'd10, 4'd9, 0, 16'h0000, 4'd9), 1, 1, 16'h7FFF, 5'h06, 16'h7FFF);
        addVec(idle(4'd10),                               0, 0, 16'h0000, 5'h06, 16'h7FFF);

        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].s);
            checkOutput(t);
            checkValue({t, ".tblWbValid"}, 32'(wbValid), 32'(vecs[i].expWbValid));
            if (vecs[i].chkData) checkValue({t, ".tblWbData"}, 32'(wbData), 32'(vecs[i].expData));
            checkValue({t, ".tblFlags"}, 32'(flags), 32'(vecs[i].expFlags));
            checkValue({t, ".tblDbgOut"}, 32'(dbgOut), 32'(vecs[i].expDbg));
        end

        // Stall with a pending write to R7; the stalled MOV must be ignored
        applyStimulus(ins(opMov, 4'd7, 4'd0, 1, 16'hABCD, 4'd7));
        checkOutput("stallSetup");
        checkValue("stall.setupData", 32'(wbData), 32'h0000ABCD);
        for (int i = 0; i < 3; i++) begin
            s = ins(opMov, 4'd7, 4'd0, 1, 16'h1111, 4'd7);
            s.stall = 1'b1;
            applyStimulus(s);
            checkOutput("stallHold");
            checkValue("stall.r7Held", 32'(dbgOut), 32'h0);
            checkValue("stall.wbDataHeld", 32'(wbData), 32'h0000ABCD);
            checkValue("stall.wbValidHeld", 32'(wbValid), 32'h1);
        end
        applyStimulus(idle(4'd7));
        checkOutput("stallRelease");
        checkValue("stall.r7Written", 32'(dbgOut), 32'h0000ABCD);
        checkValue("stall.wbEmptied", 32'(wbValid), 32'h0);

        // Commit and capture to the same register on one edge
        applyStimulus(ins(opMov, 4'd7, 4'd0, 1, 16'h2222, 4'd7));
        checkOutput("sameReg1");
        applyStimulus(ins(opMov, 4'd7, 4'd0, 1, 16'h3333, 4'd7));
        checkOutput("sameReg2");
        checkValue("sameReg.r7Old", 32'(dbgOut), 32'h00002222);
        checkValue("sameReg.wbNew", 32'(wbData), 32'h00003333);
        applyStimulus(idle(4'd7));
        checkOutput("sameReg3");
        checkValue("sameReg.r7New", 32'(dbgOut), 32'h00003333);

        // R0 behaviour in both builds, including forwarding from R0
        applyStimulus(ins(opMov, 4'd0, 4'd0, 1, 16'h0009, 4'd0));
        checkOutput("r0Mov");
        applyStimulus(ins(opAdd, 4'd0, 4'd0, 1, 16'h0001, 4'd0));
        checkOutput("r0Add");
        checkValue("r0.normalFwd", 32'(wbData), 32'h0000000A);
        checkValue("r0.zeroNoFwd", 32'(wbDataZ), 32'h00000001);
        checkValue("r0.zeroDbg", 32'(dbgOutZ), 32'h0);
        applyStimulus(idle(4'd0));
        checkOutput("r0Idle");
        checkValue("r0.normalDbg", 32'(dbgOut), 32'h0000000A);
        checkValue("r0.zeroDbgLate", 32'(dbgOutZ), 32'h0);

        // Reset with a write pending and a new instruction presented
        applyStimulus(ins(opMov, 4'd11, 4'd0, 1, 16'h5555, 4'd11));
        checkOutput("rstSetup");
        s = ins(opMov, 4'd12, 4'd0, 1, 16'h0007, 4'd11);
        s.rst = 1'b1;
        applyStimulus(s);
        checkOutput("rstEdge");
        checkValue("rst.wbValid", 32'(wbValid), 32'h0);
        checkValue("rst.flags", 32'(flags), 32'h0);
        checkValue("rst.r11", 32'(dbgOut), 32'h0);
        applyStimulus(idle(4'd1));
        checkOutput("rstAfter1");
        checkValue("rst.r1Cleared", 32'(dbgOut), 32'h0);
        applyStimulus(idle(4'd11));
        checkOutput("rstAfter2");
        checkValue("rst.r11Discarded", 32'(dbgOut), 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 500; i++) begin
            s.valid = ($urandom_range(3) != 0);
            s.stall = ($urandom_range(4) == 0);
            s.rst   = ($urandom_range(80) == 0);
            s.rd    = 4'($urandom_range(15));
            s.rs    = 4'($urandom_range(15));
            s.immS  = 1'($urandom_range(1));
            s.op    = 4'($urandom_range(9));
            s.dbg   = 4'($urandom_range(15));
            case ($urandom_range(7))
                0: s.imm = 16'h0000;
                1: s.imm = 16'hFFFF;
                2: s.imm = 16'h8000;
                3: s.imm = 16'h7FFF;
                default: s.imm = 16'($urandom);
            endcase
            applyStimulus(s);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
